// File: rtl/ecbot_cam_pkg.sv
// Shared types and default geometry for the camera capture path.
package ecbot_cam_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT_FRAME,
        ST_CAPTURE,
        ST_DONE
    } cap_state_e;

    localparam int H_ACTIVE_DEF = 254;   // pixels kept per line (even, <= 256)
    localparam int V_ACTIVE_DEF = 96;    // lines kept per frame (<= 128)
    localparam int AW_DEF       = 14;    // buffer word-address width
    localparam int PIX_W        = 8;
    localparam int WORD_W       = 16;

endpackage

// File: rtl/buf_arbiter.sv
// Single-port buffer arbiter: camera writes win, CPU gets the next free cycle.
module buf_arbiter #(
    parameter int AW = 14,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cam_wr_i,
    input  logic [AW-1:0] cam_addr_i,
    input  logic [DW-1:0] cam_wdata_i,
    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_wdata_i,
    output logic          cpu_ack_o,
    output logic [DW-1:0] cpu_rdata_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i
);
    // run_q keeps the port quiet in the first cycle out of reset;
    // rd_pend_q marks the cycle in which read data returns from the RAM.
    logic run_q, rd_pend_q, rd_pend_d, cpu_gnt;

    // Camera pixels arrive at most every other cycle, so a blocked CPU
    // request always finds a free slot one cycle later.
    assign cpu_gnt   = run_q & cpu_req_i & ~cam_wr_i & ~rd_pend_q;
    assign rd_pend_d = cpu_gnt & ~cpu_we_i;

    // Track reset release and the outstanding read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q     <= 1'b0;
            rd_pend_q <= 1'b0;
        end else begin
            run_q     <= 1'b1;
            rd_pend_q <= rd_pend_d;
        end
    end

    // Memory-port mux and CPU handshake
    always_comb begin
        mem_en_o    = cam_wr_i | cpu_gnt;
        mem_we_o    = cam_wr_i | (cpu_gnt & cpu_we_i);
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (cam_wr_i) begin
            mem_addr_o  = cam_addr_i;
            mem_wdata_o = cam_wdata_i;
        end else if (cpu_gnt) begin
            mem_addr_o  = cpu_addr_i;
            mem_wdata_o = cpu_wdata_i;
        end
        cpu_ack_o   = (cpu_gnt & cpu_we_i) | rd_pend_q;
        cpu_rdata_o = rd_pend_q ? mem_rdata_i : '0;
    end

endmodule

// File: rtl/capture_seq.sv
// Frame capture sequencer: waits for a trigger, stores one frame of
// pixel pairs into the line buffer and shares the buffer with the CPU.
module capture_seq
    import ecbot_cam_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int AW       = AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture_trigger,
    input  logic              cvsync,
    input  logic              chsync,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  ycbcr,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [AW-1:0]     cpu_addr,
    input  logic [WORD_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [WORD_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              capture_done,
    output logic              busy,
    output logic              frame_short
);
    localparam logic [8:0] H_LIM = 9'(H_ACTIVE);
    localparam logic [7:0] V_LIM = 8'(V_ACTIVE);

    cap_state_e        state_q, state_d;
    logic              arm_ok_q, trig_q, cvs_q, chs_q;
    logic [8:0]        col_q, col_d;
    logic [7:0]        line_q, line_d;
    logic [PIX_W-1:0]  even_q, even_d;
    logic              wr_q, wr_d;
    logic [AW-1:0]     waddr_q, waddr_d, pix_addr;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              done_q, done_d, short_q, short_d;
    logic              trig_rise, cvs_rise, cvs_fall, line_end, last_line;

    // arm_ok_q suppresses a trigger that is already high when reset lifts.
    assign trig_rise = capture_trigger & ~trig_q & arm_ok_q;
    assign cvs_rise  = cvsync & ~cvs_q;
    assign cvs_fall  = ~cvsync & cvs_q;
    assign line_end  = ~chsync & chs_q & (col_q != 9'd0);
    assign last_line = (line_q + 8'd1) == V_LIM;
    assign pix_addr  = AW'(32'(line_q) * 32'(H_ACTIVE / 2) + 32'(col_q[8:1]));

    // State, counters, edge history and the registered camera write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            arm_ok_q <= 1'b0;
            trig_q   <= 1'b0;
            cvs_q    <= 1'b0;
            chs_q    <= 1'b0;
            col_q    <= '0;
            line_q   <= '0;
            even_q   <= '0;
            wr_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            short_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            arm_ok_q <= 1'b1;
            trig_q   <= capture_trigger;
            cvs_q    <= cvsync;
            chs_q    <= chsync;
            col_q    <= col_d;
            line_q   <= line_d;
            even_q   <= even_d;
            wr_q     <= wr_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            done_q   <= done_d;
            short_q  <= short_d;
        end
    end

    // Next-state, pixel packing and line/frame bookkeeping
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        line_d  = line_q;
        even_d  = even_q;
        wr_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        short_d = short_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (trig_rise) begin
                    state_d = ST_ARM;
                    done_d  = 1'b0;
                    short_d = 1'b0;
                end
            end
            ST_ARM: begin
                if (!cvsync) state_d = ST_WAIT_FRAME;
            end
            ST_WAIT_FRAME: begin
                if (cvs_rise) begin
                    state_d = ST_CAPTURE;
                    col_d   = '0;
                    line_d  = '0;
                end
            end
            ST_CAPTURE: begin
                // Columns past H_ACTIVE are neither counted nor stored.
                if (pix_valid && chsync && col_q < H_LIM) begin
                    col_d = col_q + 9'd1;
                    if (!col_q[0]) begin
                        even_d = ycbcr;
                    end else begin
                        wr_d    = 1'b1;
                        waddr_d = pix_addr;
                        wdata_d = {ycbcr, even_q};
                    end
                end
                // A dangling even pixel is simply forgotten at line end.
                if (line_end) begin
                    line_d = line_q + 8'd1;
                    col_d  = '0;
                end
                if (line_end && last_line) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (cvs_fall) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    short_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy         = (state_q == ST_ARM) || (state_q == ST_WAIT_FRAME) ||
                          (state_q == ST_CAPTURE);
    assign capture_done = done_q;
    assign frame_short  = short_q;

    buf_arbiter #(.AW(AW), .DW(WORD_W)) u_arb (
        .clk         (clk),
        .reset       (reset),
        .cam_wr_i    (wr_q),
        .cam_addr_i  (waddr_q),
        .cam_wdata_i (wdata_q),
        .cpu_req_i   (cpu_req),
        .cpu_we_i    (cpu_we),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_ack_o   (cpu_ack),
        .cpu_rdata_o (cpu_rdata),
        .mem_en_o    (mem_en),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

endmodule
